// File: rtl/rprelu_act_if.sv
// Vector stream bundle for the RPReLU stage: upstream vector in, activated vector
// plus valid/frame marker out.
interface rprelu_act_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128
);
    logic                         data_in_valid;
    logic signed [DATA_WIDTH-1:0] data_in [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] data_out [CHANNEL_NUM];
    logic                         data_out_valid;
    logic                         frame_done;

    modport master (
        output data_in_valid, data_in,
        input  data_out, data_out_valid, frame_done
    );

    modport slave (
        input  data_in_valid, data_in,
        output data_out, data_out_valid, frame_done
    );
endinterface

// File: rtl/rprelu_act.sv
// Per-channel RPReLU activation, y = f(x - gamma) + zeta, two-stage pipeline with
// saturated output and a per-feature-map last-pixel flag.
module rprelu_act #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int BETA_FRAC   = 8,
    parameter int FM_PIXELS   = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    rprelu_act_if.slave                  bus,
    input  logic signed [PARA_WIDTH-1:0] rp_gamma [CHANNEL_NUM],
    input  logic signed [PARA_WIDTH-1:0] rp_beta  [CHANNEL_NUM],
    input  logic signed [PARA_WIDTH-1:0] rp_zeta  [CHANNEL_NUM]
);
    localparam int DW1 = DATA_WIDTH + 1;
    localparam int PRW = DATA_WIDTH + PARA_WIDTH + 1;
    localparam int SW  = PRW + 1;
    localparam int CW  = (FM_PIXELS > 1) ? $clog2(FM_PIXELS) : 1;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - 1;

    logic signed [DW1-1:0]        d_q   [CHANNEL_NUM];
    logic                         valid1_q;
    logic [CW-1:0]                pix_cnt_q;
    logic                         last_pix;

    logic signed [PRW-1:0]        prod  [CHANNEL_NUM];
    logic signed [PRW-1:0]        t_val [CHANNEL_NUM];
    logic signed [SW-1:0]         s_val [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] sat   [CHANNEL_NUM];

    // Stage 1: pre-shift by gamma, one guard bit so the difference never wraps.
    // NOTE: the datapath registers are cleared on reset because the block contract
    // requires data_out and all pipeline state to read zero after reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid1_q <= 1'b0;
            for (int i = 0; i < CHANNEL_NUM; i++) d_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid1_q <= bus.data_in_valid;
            if (bus.data_in_valid) begin
                for (int i = 0; i < CHANNEL_NUM; i++)
                    d_q[i] <= DW1'(bus.data_in[i]) - DW1'(rp_gamma[i]);
            end
        end
    end

    // Stage 2 combinational: slope on negative side (floor via arithmetic shift),
    // post-shift by zeta, then clamp into the output range.
    // NOTE: every comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            prod[i]  = PRW'(d_q[i]) * PRW'(rp_beta[i]);
            t_val[i] = d_q[i][DW1-1] ? (prod[i] >>> BETA_FRAC) : PRW'(d_q[i]);
            s_val[i] = SW'(t_val[i]) + SW'(rp_zeta[i]);
            if (s_val[i] > SAT_MAX)
                sat[i] = DATA_WIDTH'(SAT_MAX);
            else if (s_val[i] < SAT_MIN)
                sat[i] = DATA_WIDTH'(SAT_MIN);
            else
                sat[i] = s_val[i][DATA_WIDTH-1:0];
        end
    end

    assign last_pix = (pix_cnt_q == CW'(FM_PIXELS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.data_out_valid <= 1'b0;
            bus.frame_done     <= 1'b0;
            pix_cnt_q          <= '0;
            for (int i = 0; i < CHANNEL_NUM; i++) bus.data_out[i] <= '0;
        end else begin
            bus.data_out_valid <= valid1_q;
            bus.frame_done     <= valid1_q && last_pix;
            if (valid1_q) begin
                pix_cnt_q <= last_pix ? '0 : pix_cnt_q + 1'b1;
                for (int i = 0; i < CHANNEL_NUM; i++) bus.data_out[i] <= sat[i];
            end
        end
    end
endmodule

// File: tb/tb_rprelu_act.sv
// Directed bench for rprelu_act: table of single-vector cases, stream/frame timing,
// mid-stream reset and per-channel independence against a reference model.
module tb_rprelu_act;
    localparam int DW = 16;
    localparam int PW = 16;
    localparam int CH = 128;
    localparam int BF = 8;
    localparam int FM = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic signed [PW-1:0] rp_gamma [CH];
    logic signed [PW-1:0] rp_beta  [CH];
    logic signed [PW-1:0] rp_zeta  [CH];

    rprelu_act_if #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH)) bus ();

    rprelu_act #(
        .DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CH),
        .BETA_FRAC(BF), .FM_PIXELS(FM)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .rp_gamma(rp_gamma), .rp_beta(rp_beta), .rp_zeta(rp_zeta)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int seq = 0;
    longint exp_last = 0;

    typedef struct {
        longint x, g, b, z, exp_y;
    } vec_t;
    vec_t tbl [11];

    longint xs [CH];
    longint gs [CH];
    longint bs [CH];
    longint zs [CH];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    // Reference: integer arithmetic with explicit floor division.
    function automatic longint model(input longint x, input longint g, input longint b, input longint z);
        longint d, p, t, s;
        d = x - g;
        if (d >= 0) t = d;
        else begin
            p = d * b;
            if (p >= 0) t = p / (64'sd1 << BF);
            else        t = -((-p + (64'sd1 << BF) - 1) / (64'sd1 << BF));
        end
        s = t + z;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic drive_all(input longint x, input longint g, input longint b, input longint z);
        for (int c = 0; c < CH; c++) begin
            bus.data_in[c] = DW'(x);
            rp_gamma[c]    = PW'(g);
            rp_beta[c]     = PW'(b);
            rp_zeta[c]     = PW'(z);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.data_in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        exp_last = 0;
    endtask

    // Sends n vectors separated by gap idle cycles and checks every cycle's outputs.
    task automatic run_stream(input int n, input int gap);
        logic   p1_v = 1'b0, p2_v = 1'b0, drv;
        longint p1_d = 0, p2_d = 0, dval;
        int     sent = 0;
        bit     exp_fd;
        for (int c = 0; c < n * (gap + 1) + 2; c++) begin
            @(negedge clk);
            exp_fd = 1'b0;
            if (p2_v) begin
                pulses++;
                exp_last = p2_d;
                exp_fd = (pulses % FM == 0);
            end
            check($sformatf("stream c%0d valid", c), 64'(bus.data_out_valid), 64'(p2_v));
            check($sformatf("stream c%0d frame_done", c), 64'(bus.frame_done), 64'(exp_fd));
            check($sformatf("stream c%0d data", c), bus.data_out[0], exp_last);
            drv  = (c % (gap + 1) == 0) && (sent < n);
            dval = 1000 + seq;
            if (drv) begin
                sent++;
                seq++;
                for (int k = 0; k < CH; k++) bus.data_in[k] = DW'(dval);
            end
            bus.data_in_valid = drv;
            p2_v = p1_v; p2_d = p1_d;
            p1_v = drv;  p1_d = dval;
        end
    endtask

    initial begin
        int mism;
        tbl[0]  = '{100,    20,     256,  5,      85};
        tbl[1]  = '{-100,   0,      64,   0,      -25};
        tbl[2]  = '{-3,     0,      128,  0,      -2};
        tbl[3]  = '{32767,  -32768, 256,  100,    32767};
        tbl[4]  = '{-32768, 32767,  256,  0,      -32768};
        tbl[5]  = '{0,      0,      256,  -32768, -32768};
        tbl[6]  = '{0,      0,      256,  32767,  32767};
        tbl[7]  = '{-50,    0,      0,    7,      7};
        tbl[8]  = '{-10,    0,      -256, 0,      10};
        tbl[9]  = '{5,      5,      -300, 3,      3};
        tbl[10] = '{-1,     0,      1,    0,      -1};

        bus.data_in_valid = 1'b0;
        drive_all(0, 0, 256, 0);
        do_reset();
        check("reset valid", 64'(bus.data_out_valid), 64'd0);
        check("reset frame_done", 64'(bus.frame_done), 64'd0);
        check("reset data", bus.data_out[0], 64'sd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_all(tbl[i].x, tbl[i].g, tbl[i].b, tbl[i].z);
            bus.data_in_valid = 1'b1;
            @(negedge clk);
            bus.data_in_valid = 1'b0;
            check($sformatf("tbl%0d early valid", i), 64'(bus.data_out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("tbl%0d valid", i), 64'(bus.data_out_valid), 64'd1);
            check($sformatf("tbl%0d y", i), bus.data_out[0], tbl[i].exp_y);
            mism = 0;
            for (int c = 0; c < CH; c++)
                if (bus.data_out[c] !== DW'(tbl[i].exp_y)) mism++;
            check($sformatf("tbl%0d all-ch mismatches", i), 64'(mism), 64'd0);
        end

        do_reset();
        drive_all(0, 0, 256, 0);
        run_stream(10, 0);
        run_stream(3, 1);

        // Mid-stream reset with two vectors in flight.
        @(negedge clk);
        for (int c = 0; c < CH; c++) bus.data_in[c] = 16'sd5555;
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < CH; c++) bus.data_in[c] = 16'sd6666;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bus.data_in_valid = 1'b0;
        check("rst valid", 64'(bus.data_out_valid), 64'd0);
        check("rst frame_done", 64'(bus.frame_done), 64'd0);
        check("rst data ch0", bus.data_out[0], 64'sd0);
        check("rst data ch127", bus.data_out[CH-1], 64'sd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("post-rst idle%0d valid", k), 64'(bus.data_out_valid), 64'd0);
        end
        pulses = 0;
        exp_last = 0;
        run_stream(4, 0);

        // Per-channel independence against the model.
        for (int c = 0; c < CH; c++) begin
            xs[c] = longint'($signed(16'($urandom())));
            gs[c] = longint'($signed(16'($urandom())));
            bs[c] = longint'($signed(16'($urandom_range(0, 600))));
            zs[c] = longint'($signed(16'($urandom())));
        end
        xs[0]    = 300;    gs[0]    = 100;   bs[0]    = 77;  zs[0]    = -5;
        xs[1]    = -777;   gs[1]    = 23;    bs[1]    = 45;  zs[1]    = 11;
        xs[CH-1] = 30000;  gs[CH-1] = -5000; bs[CH-1] = 256; zs[CH-1] = 2000;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            bus.data_in[c] = DW'(xs[c]);
            rp_gamma[c]    = PW'(gs[c]);
            rp_beta[c]     = PW'(bs[c]);
            rp_zeta[c]     = PW'(zs[c]);
        end
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        @(negedge clk);
        check("chan valid", 64'(bus.data_out_valid), 64'd1);
        check("chan ch0", bus.data_out[0], 64'sd195);
        check("chan ch1", bus.data_out[1], -64'sd130);
        check("chan ch127", bus.data_out[CH-1], 64'sd32767);
        mism = 0;
        for (int c = 0; c < CH; c++)
            if (longint'(bus.data_out[c]) != model(xs[c], gs[c], bs[c], zs[c])) mism++;
        check("chan model mismatches", 64'(mism), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rprelu_act.md
Name: rprelu_act

Overview:
- Per-channel RPReLU activation stage directly downstream of the BN + residual stage.
- Consumes the saturated 16-bit BN/residual vector, one vector per pixel.
- Applies y = f(x - gamma) + zeta, with f(t) = t for t >= 0 and f(t) = beta*t for t < 0 (beta fixed-point).
- Emits the saturated 16-bit result to the next layer's binarizer/residual buffer, and flags the last pixel of each feature map.

Parameters:
- DATA_WIDTH, 16, width of data_in / data_out elements (signed).
- PARA_WIDTH, 16, width of gamma / beta / zeta elements (signed).
- CHANNEL_NUM, 128, channels per vector.
- BETA_FRAC, 8, fractional bits of beta (beta = 256 means 1.0).
- FM_PIXELS, 1024, accepted vectors per feature map; frame_done period.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, synchronous, active-low
- data_in_valid  input  1  data_in holds a valid vector this cycle
- data_in  input  signed DATA_WIDTH x CHANNEL_NUM  BN/residual output
- rp_gamma  input  signed PARA_WIDTH x CHANNEL_NUM  pre-shift per channel
- rp_beta  input  signed PARA_WIDTH x CHANNEL_NUM  negative slope, Q(BETA_FRAC)
- rp_zeta  input  signed PARA_WIDTH x CHANNEL_NUM  post-shift per channel
- data_out  output  signed DATA_WIDTH x CHANNEL_NUM  activated vector
- data_out_valid  output  1  data_out valid, one-cycle pulse per vector
- frame_done  output  1  high together with data_out_valid on the last vector of a feature map

Behaviour:
- Clock and reset: one clock. All registers clear only on a rising clk edge with rstn = 0.
- Reset values: data_out = 0, data_out_valid = 0, frame_done = 0, internal pipeline registers = 0, pixel counter = 0.
- Reset mid-stream: in-flight vectors are discarded and no valid is emitted afterwards for them.
- Pipeline: fixed latency of 2 cycles. data_in_valid at edge N gives data_out_valid at edge N+2. Throughput is one vector per cycle; back-to-back and gapped inputs are both supported.
- Stage 1, on data_in_valid: d[i] = data_in[i] - rp_gamma[i], computed at DATA_WIDTH+1 bits with no saturation. Register d and valid1. Without valid, d holds and valid1 = 0.
- Stage 2, on valid1:
  - If d[i] >= 0: t = d[i].
  - Otherwise: t = (d[i] * rp_beta[i]) >>> BETA_FRAC. The product is full width (DATA_WIDTH+PARA_WIDTH+1 bits) and the shift is arithmetic, i.e. floor rounding.
  - s = t + rp_zeta[i], sign-extended with one extra bit.
  - data_out[i] = s clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - data_out_valid = valid1.
  - When valid1 = 0, data_out holds its last value and data_out_valid = 0.
- Parameter timing: parameters are sampled in the stage that uses them. gamma is sampled in stage 1; beta and zeta are sampled in stage 2. Parameters must be stable while a layer runs.
- Pixel counter: counts cycles with data_out_valid = 1 over 0..FM_PIXELS-1.
  - frame_done = 1 in the same cycle as the data_out_valid whose count equals FM_PIXELS-1; 0 otherwise.
  - The counter then wraps to 0. There is no idle gap required between frames.
- Boundary: beta = 0 gives t = 0 for negative d. Beta negative is legal. d = 0 takes the positive branch.

Test Plan:
- Positive branch: x=100, gamma=20, zeta=5 -> data_out=85, two cycles after data_in_valid.
- Negative branch with floor: x=-100, gamma=0, beta=64, zeta=0 -> -25. x=-3, gamma=0, beta=128, zeta=0 -> -2 (floor of -1.5).
- Saturation:
  - x=32767, gamma=-32768, zeta=100 -> 32767.
  - x=-32768, gamma=32767, beta=256, zeta=0 -> -32768.
  - x=0, gamma=0, zeta=-32768, then zeta=32767 -> -32768, then 32767.
- Valid timing with FM_PIXELS=4:
  - 10 back-to-back vectors -> 10 data_out_valid pulses at N+2..N+11, frame_done on pulses 4 and 8.
  - Then 3 gapped vectors (1 idle cycle between) -> data_out holds during gaps, frame_done on the 12th pulse.
- Reset mid-stream: rstn=0 for 1 cycle while 2 vectors are in flight -> no data_out_valid for them, data_out=0. Counter restarts, so frame_done falls on the 4th post-reset vector.
- Per-channel independence with CHANNEL_NUM=128: ch0 positive, ch1 negative, ch127 saturating in the same vector -> each matches a golden model bit-exactly.
